// File: rtl/qr_sched_pkg.sv
// qr_sched_pkg: shared constants and the state type for the QR feed scheduler.
package qr_sched_pkg;

  localparam int QR_DATA_W         = 48;
  localparam int DEF_WORDS_PER_GRP = 200;   // 10 RE x 20 words
  localparam int DEF_OUTS_PER_GRP  = 10;    // engine result beats per group
  localparam int DEF_GRPS_PER_PKT  = 100;   // 1000 RE per packet
  localparam int DEF_TIMEOUT_CYC   = 4096;  // DRAIN watchdog limit

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } sched_state_e;

endpackage

// File: rtl/qr_wrap_counter.sv
// qr_wrap_counter: counts 0..MAX on inc_i, wraps to 0 after MAX; clr_i wins over inc_i.
module qr_wrap_counter #(
  parameter int MAX = 1,
  localparam int W = (MAX < 1) ? 1 : $clog2(MAX + 1)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o,
  output logic         at_max_o
);

  localparam logic [W-1:0] MAX_V = W'(MAX);
  localparam logic [W-1:0] ONE_V = W'(1);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: clear, else wrap-increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = (cnt_q == MAX_V) ? '0 : cnt_q + ONE_V;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o    = cnt_q;
  assign at_max_o = (cnt_q == MAX_V);

endmodule

// File: rtl/qr_feed_scheduler.sv
// qr_feed_scheduler: feeds QR_Engine in groups of WORDS_PER_GRP words, waits for the
// engine's last output of each group, and repeats for GRPS_PER_PKT groups.
// Optional macro QR_SCHED_TIMEOUT_EN adds a DRAIN watchdog (o_timeout); without it
// DRAIN waits indefinitely and o_timeout is tied 0.
//
// Handshake: a word moves from upstream when i_src_vld and o_src_rdy are both high on a
// rising clock edge; o_src_rdy depends only on state (high throughout FEED), never on
// i_src_vld. A word offered in the same cycle as i_abort is consumed and discarded.
module qr_feed_scheduler
  import qr_sched_pkg::*;
#(
  parameter int WORDS_PER_GRP = DEF_WORDS_PER_GRP,
  parameter int OUTS_PER_GRP  = DEF_OUTS_PER_GRP,
  parameter int GRPS_PER_PKT  = DEF_GRPS_PER_PKT,
  parameter int TIMEOUT_CYC   = DEF_TIMEOUT_CYC
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic                                i_start,
  input  logic                                i_abort,
  input  logic                                i_src_vld,
  input  logic [QR_DATA_W-1:0]                i_src_data,
  output logic                                o_src_rdy,
  output logic                                o_eng_trig,
  output logic [QR_DATA_W-1:0]                o_eng_data,
  input  logic                                i_eng_rd_vld,
  input  logic                                i_eng_last,
  output logic                                o_busy,
  output logic                                o_done,
  output logic [$clog2(GRPS_PER_PKT+1)-1:0]   o_grp_cnt,
  output logic                                o_err,
  output logic                                o_timeout,
  output logic [1:0]                          o_dbg_state
);

  localparam int WW = $clog2(WORDS_PER_GRP);
  localparam int OW = $clog2(OUTS_PER_GRP);
  localparam int GW = $clog2(GRPS_PER_PKT + 1);
  localparam logic [GW-1:0] LAST_GRP = GW'(GRPS_PER_PKT - 1);

  sched_state_e          state_q, state_d;
  logic                  xfer, pkt_start, err_set, tmo_set, grp_inc, out_clr, cnt_clr;
  logic                  word_at_max, out_at_max, grp_at_max, tmo_at_max;
  logic [WW-1:0]         word_cnt;
  logic [OW-1:0]         out_cnt;
  logic [GW-1:0]         grp_cnt;
  logic                  trig_q, err_q;
  logic [QR_DATA_W-1:0]  data_q;
  logic                  unused_bits;

  // The abort cycle drops any word on the bus so nothing reaches the engine afterwards.
  assign xfer    = i_src_vld && (state_q == ST_FEED) && !i_abort;
  assign cnt_clr = i_abort || pkt_start;

  // Next state, error detection and counter control.
  always_comb begin
    state_d   = state_q;
    pkt_start = 1'b0;
    err_set   = 1'b0;
    tmo_set   = 1'b0;
    grp_inc   = 1'b0;
    out_clr   = 1'b0;
    if (i_abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (i_start) begin
            state_d   = ST_FEED;
            pkt_start = 1'b1;
          end else if (i_eng_last || i_eng_rd_vld) begin
            err_set = 1'b1;
          end
        end
        ST_FEED: begin
          if (i_eng_last) err_set = 1'b1;
          if (xfer && word_at_max) state_d = ST_DRAIN;
        end
        ST_DRAIN: begin
          if (i_eng_last) begin
            grp_inc = 1'b1;
            out_clr = 1'b1;
            // last must land on the final expected result beat of the group
            if (!(i_eng_rd_vld && out_at_max)) err_set = 1'b1;
            state_d = (grp_cnt == LAST_GRP) ? ST_DONE : ST_FEED;
          end else if (tmo_at_max) begin
            tmo_set = 1'b1;
            err_set = 1'b1;
            out_clr = 1'b1;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Engine feed: one-cycle registered copy of each accepted word; data holds otherwise.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      trig_q <= 1'b0;
      data_q <= '0;
    end else begin
      trig_q <= xfer;
      if (xfer) data_q <= i_src_data;
    end
  end

  // Sticky protocol error, cleared only when a new packet starts.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)          err_q <= 1'b0;
    else if (pkt_start) err_q <= 1'b0;
    else if (err_set)   err_q <= 1'b1;
  end

  qr_wrap_counter #(.MAX(WORDS_PER_GRP - 1)) u_word_cnt (
    .clk_i(i_clk), .rst_i(i_rst), .inc_i(xfer), .clr_i(cnt_clr),
    .cnt_o(word_cnt), .at_max_o(word_at_max)
  );

  qr_wrap_counter #(.MAX(OUTS_PER_GRP - 1)) u_out_cnt (
    .clk_i(i_clk), .rst_i(i_rst),
    .inc_i(i_eng_rd_vld && ((state_q == ST_FEED) || (state_q == ST_DRAIN))),
    .clr_i(cnt_clr || out_clr),
    .cnt_o(out_cnt), .at_max_o(out_at_max)
  );

  qr_wrap_counter #(.MAX(GRPS_PER_PKT)) u_grp_cnt (
    .clk_i(i_clk), .rst_i(i_rst), .inc_i(grp_inc), .clr_i(cnt_clr),
    .cnt_o(grp_cnt), .at_max_o(grp_at_max)
  );

`ifdef QR_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC);
  logic [TW-1:0] tmo_cnt;
  logic          tmo_q;

  qr_wrap_counter #(.MAX(TIMEOUT_CYC - 1)) u_tmo_cnt (
    .clk_i(i_clk), .rst_i(i_rst),
    .inc_i(state_q == ST_DRAIN), .clr_i(state_d != ST_DRAIN),
    .cnt_o(tmo_cnt), .at_max_o(tmo_at_max)
  );

  // Sticky watchdog flag, cleared when a new packet starts.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)          tmo_q <= 1'b0;
    else if (pkt_start) tmo_q <= 1'b0;
    else if (tmo_set)   tmo_q <= 1'b1;
  end

  assign o_timeout   = tmo_q;
  assign unused_bits = ^{word_cnt, out_cnt, grp_at_max, tmo_cnt};
`else
  assign tmo_at_max  = 1'b0;
  assign o_timeout   = 1'b0;
  assign unused_bits = ^{word_cnt, out_cnt, grp_at_max, tmo_set, (TIMEOUT_CYC > 0)};
`endif

  assign o_src_rdy   = (state_q == ST_FEED);
  assign o_eng_trig  = trig_q;
  assign o_eng_data  = data_q;
  assign o_busy      = (state_q == ST_FEED) || (state_q == ST_DRAIN);
  assign o_done      = (state_q == ST_DONE);
  assign o_grp_cnt   = grp_cnt;
  assign o_err       = err_q;
  assign o_dbg_state = state_q;

endmodule
